devil_in_fpga_core: RTL and testbench
=====================================

Name: devil_in_fpga_core

Overview:
- Fault-injection ("devil") engine inside the ACE snoop-slave IP.
- When armed through a control register, it takes over the snoop response channel and replies with programmable delays on CRVALID, CDVALID or CDLAST.
- Runs in one-shot mode (triggered by the host snoop FSM) or continuous mode (free-running).
- Reports its state and a response count to the AXI-Lite status register.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: width of all register ports.
- C_ACE_DATA_WIDTH, 128: width of o_rdata; must be a multiple of 32.
- DEVIL_EN, 10: host snoop-FSM state code meaning "devil owns the channel".

Ports:
- ace_aclk  in  1  clock.
- ace_aresetn  in  1  synchronous active-low reset.
- i_snoop_state  in  4  current host snoop-FSM state.
- o_fsm_devil_state  out  4  current devil state code.
- i_control_reg  in  32  [0] EN; [4:1] test; [8:5] function; [13:9] crresp value; [16] OSH_EN; [17] CON_EN.
- i_read_status_reg  in  32  user-written status; bit31=1 clears the response counter.
- o_write_status_reg  out  32  [0] busy (state≠IDLE); [1] osh_done; [7:4] state; [31:16] response count.
- i_delay_reg  in  32  delay length in cycles.
- i_acsnoop_reg  in  32  data pattern source.
- i_base_addr_reg  in  32  reserved, unused.
- i_addr_size_reg  in  32  reserved, unused.
- o_rdata  out  C_ACE_DATA_WIDTH  snoop data: i_acsnoop_reg replicated.
- o_crresp  out  5  snoop response.
- o_crvalid  out  1  response valid.
- o_cdvalid  out  1  data valid.
- o_cdlast  out  1  last data beat.

Behaviour:
- Clocking and reset: all state updates on the rising edge of ace_aclk. Synchronous active-low reset gives state IDLE, counters 0, osh_done 0, all outputs 0.
- State codes: IDLE=0, ONE_SHOT_DELAY=1, CONTINUOS_DELAY=2, RESPONSE=3, DELAY=4, END=5. State is registered; o_fsm_devil_state = state.
- Test codes: FUZZING=0, REPLY_WITH_DELAY_CRVALID=1, REPLY_WITH_DELAY_CDVALID=2, REPLY_WITH_DELAY_CDLAST=3. Codes ≥4 behave as 1.
- Function field: informational only; OSH_EN and CON_EN select the mode.
- IDLE transitions:
  - EN & OSH_EN & !osh_done & i_snoop_state==DEVIL_EN → ONE_SHOT_DELAY.
  - Otherwise, EN & CON_EN → CONTINUOS_DELAY (no snoop trigger needed).
  - OSH has priority over CON.
- ONE_SHOT_DELAY / CONTINUOS_DELAY:
  - 32-bit counter cleared on entry; → RESPONSE when counter ≥ i_delay_reg−1.
  - Delay 0 and delay 1 both give one cycle.
  - Test FUZZING skips the count: exactly one cycle.
- RESPONSE (exactly 1 cycle):
  - o_crvalid=1, o_crresp=control[13:9].
  - Response counter increments and wraps at 16 bits.
  - Tests 0/1 go to the exit state; tests 2/3 go to DELAY.
- DELAY (data phase):
  - Test 2: stall i_delay_reg cycles (min 1) with cdvalid=0, then 4 consecutive beats with cdvalid=1; cdlast=1 on beat 3.
  - Test 3: beats 0–2 back-to-back, stall i_delay_reg cycles (min 1), then beat 3 with cdvalid=cdlast=1.
  - Then go to the exit state.
- Exit state: one-shot goes to END; continuous goes to CONTINUOS_DELAY if CON_EN, else IDLE.
- END (1 cycle): sets osh_done, → IDLE.
- osh_done: cleared whenever OSH_EN=0. A one-shot fires once per OSH_EN assertion even if the snoop state stays at DEVIL_EN.
- Output decoding:
  - o_crvalid and o_crresp are non-zero only in RESPONSE.
  - o_cdvalid and o_cdlast are non-zero only on data beats.
  - o_rdata is valid only during beats and 0 otherwise.
- EN=0 in any state: → IDLE next cycle, counters cleared, outputs 0.
- Control changes mid-sequence: clearing CON_EN mid-sequence lets the current response finish, then → IDLE.
- Counter clear: i_read_status_reg[31]=1 clears the response counter. If it coincides with an increment, the clear wins.
- Reset asserted mid-operation: reset wins.

Test Plan:
- Reset: hold ace_aresetn=0 for 10 cycles → state 0, all outputs 0, status 0.
- One-shot CRVALID: EN=1, test=1, crresp=0, OSH_EN=1, delay=1, snoop_state=10 → states 1,3,5,0. Exactly one crvalid pulse with crresp=0. No retrigger while OSH_EN is held; count=1.
- Continuous: then OSH_EN=0, snoop_state=0, CON_EN=1, delay=1 → RESPONSE/CONTINUOS_DELAY alternate. Five crvalid pulses in 10 cycles; count increments to 6.
- Delay length: delay=5, test=1, continuous → crvalid period of 6 cycles.
- CDVALID: test=2, delay=3, crresp=5'h01, acsnoop=32'hA5A5A5A5 → crvalid, 3-cycle gap, 4 cdvalid beats with rdata={4{32'hA5A5A5A5}}, cdlast on the 4th beat.
- CDLAST and abort: test=3, delay=2 → 3 beats, 2-cycle gap, beat with cdlast. Separately, clearing EN mid-delay → IDLE next cycle with outputs low.

Source files
------------

// File: rtl/devil_in_fpga_core_if.sv
// Snoop response channel driven by the devil engine while it owns the channel.
interface devil_in_fpga_core_if #(
    parameter int C_ACE_DATA_WIDTH = 128
);
    logic [C_ACE_DATA_WIDTH-1:0] o_rdata;
    logic [4:0]                  o_crresp;
    logic                        o_crvalid;
    logic                        o_cdvalid;
    logic                        o_cdlast;

    modport master (
        output o_rdata, o_crresp, o_crvalid, o_cdvalid, o_cdlast
    );

    modport slave (
        input  o_rdata, o_crresp, o_crvalid, o_cdvalid, o_cdlast
    );
endinterface

// File: rtl/devil_in_fpga_core.sv
// Fault-injection engine: takes over the ACE snoop response channel and replies
// with programmable delays on CRVALID, CDVALID or CDLAST, in one-shot or continuous mode.
module devil_in_fpga_core #(
    parameter int         C_S_AXI_DATA_WIDTH = 32,
    parameter int         C_ACE_DATA_WIDTH   = 128,
    parameter logic [3:0] DEVIL_EN           = 4'd10
) (
    input  logic                          ace_aclk,
    input  logic                          ace_aresetn,
    input  logic [3:0]                    i_snoop_state,
    output logic [3:0]                    o_fsm_devil_state,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_control_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_read_status_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_write_status_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_delay_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_acsnoop_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_base_addr_reg,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size_reg,
    devil_in_fpga_core_if.master          snp
);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int REP = C_ACE_DATA_WIDTH / 32;
    localparam logic [DW-1:0] ZERO_DW  = {DW{1'b0}};
    localparam logic [DW-1:0] ONE_DW   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW:0]   THREE_X  = {{(DW-1){1'b0}}, 2'b11};
    localparam logic [1:0]    T_FUZZ   = 2'd0;
    localparam logic [1:0]    T_CRV    = 2'd1;
    localparam logic [1:0]    T_CDV    = 2'd2;
    localparam logic [1:0]    T_CDL    = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE            = 4'd0,
        S_ONE_SHOT_DELAY  = 4'd1,
        S_CONTINUOS_DELAY = 4'd2,
        S_RESPONSE        = 4'd3,
        S_DELAY           = 4'd4,
        S_END             = 4'd5
    } state_t;

    state_t                      state_r, next_state_s, exit_state_s;
    logic [DW-1:0]               cnt_r, next_cnt_s, dmin_s;
    logic [DW:0]                 last_idx_s, cnt_x_s, next_cnt_x_s;
    logic                        mode_osh_r, next_mode_osh_s, osh_done_r;
    logic [15:0]                 resp_cnt_r;
    logic [1:0]                  eff_test_s;
    logic                        en_s, osh_en_s, con_en_s, beat_s, last_s;
    logic                        crvalid_r, cdvalid_r, cdlast_r;
    logic [4:0]                  crresp_r;
    logic [C_ACE_DATA_WIDTH-1:0] rdata_r;
    logic                        unused_s;

    assign en_s         = i_control_reg[0];
    assign osh_en_s     = i_control_reg[16];
    assign con_en_s     = i_control_reg[17];
    assign dmin_s       = (i_delay_reg == ZERO_DW) ? ONE_DW : i_delay_reg;
    assign last_idx_s   = {1'b0, dmin_s} + THREE_X;
    assign cnt_x_s      = {1'b0, cnt_r};
    assign next_cnt_x_s = {1'b0, next_cnt_s};
    assign unused_s     = ^{i_base_addr_reg, i_addr_size_reg, i_read_status_reg[DW-2:0],
                            i_control_reg[DW-1:18], i_control_reg[15:14], i_control_reg[8:5]};

    // Test codes 4 and above fall back to the CRVALID-delay behaviour.
    always_comb begin
        case (i_control_reg[4:1])
            4'd0:    eff_test_s = T_FUZZ;
            4'd2:    eff_test_s = T_CDV;
            4'd3:    eff_test_s = T_CDL;
            default: eff_test_s = T_CRV;
        endcase
    end

    // Where a finished response goes: one-shot ends, continuous loops while CON_EN holds.
    always_comb begin
        if (mode_osh_r) begin
            exit_state_s = S_END;
        end else if (con_en_s) begin
            exit_state_s = S_CONTINUOS_DELAY;
        end else begin
            exit_state_s = S_IDLE;
        end
    end

    // Next-state, phase counter and mode selection.
    always_comb begin
        next_state_s    = state_r;
        next_cnt_s      = ZERO_DW;
        next_mode_osh_s = mode_osh_r;
        if (!en_s) begin
            next_state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (osh_en_s && !osh_done_r && (i_snoop_state == DEVIL_EN)) begin
                        next_state_s    = S_ONE_SHOT_DELAY;
                        next_mode_osh_s = 1'b1;
                    end else if (con_en_s) begin
                        next_state_s    = S_CONTINUOS_DELAY;
                        next_mode_osh_s = 1'b0;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
                S_ONE_SHOT_DELAY, S_CONTINUOS_DELAY: begin
                    if ((eff_test_s == T_FUZZ) || (cnt_r >= (dmin_s - ONE_DW))) begin
                        next_state_s = S_RESPONSE;
                    end else begin
                        next_cnt_s = cnt_r + ONE_DW;
                    end
                end
                S_RESPONSE: begin
                    if ((eff_test_s == T_CDV) || (eff_test_s == T_CDL)) begin
                        next_state_s = S_DELAY;
                    end else begin
                        next_state_s = exit_state_s;
                    end
                end
                S_DELAY: begin
                    if (cnt_x_s >= last_idx_s) begin
                        next_state_s = exit_state_s;
                    end else begin
                        next_cnt_s = cnt_r + ONE_DW;
                    end
                end
                S_END:   next_state_s = S_IDLE;
                default: next_state_s = S_IDLE;
            endcase
        end
    end

    // Data-phase beat decode for the upcoming cycle, so outputs can be registered.
    always_comb begin
        beat_s = 1'b0;
        last_s = 1'b0;
        if (next_state_s == S_DELAY) begin
            case (eff_test_s)
                T_CDV: begin
                    beat_s = (next_cnt_x_s >= {1'b0, dmin_s}) && (next_cnt_x_s <= last_idx_s);
                    last_s = (next_cnt_x_s == last_idx_s);
                end
                T_CDL: begin
                    beat_s = (next_cnt_x_s < THREE_X) || (next_cnt_x_s == last_idx_s);
                    last_s = (next_cnt_x_s == last_idx_s);
                end
                default: begin
                    beat_s = 1'b0;
                    last_s = 1'b0;
                end
            endcase
        end else begin
            beat_s = 1'b0;
            last_s = 1'b0;
        end
    end

    // State, counters and one-shot bookkeeping; a counter clear beats a same-cycle increment.
    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn) begin
            state_r    <= S_IDLE;
            cnt_r      <= ZERO_DW;
            mode_osh_r <= 1'b0;
            osh_done_r <= 1'b0;
            resp_cnt_r <= 16'd0;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= next_cnt_s;
            mode_osh_r <= next_mode_osh_s;
            if (!osh_en_s) begin
                osh_done_r <= 1'b0;
            end else if (state_r == S_END) begin
                osh_done_r <= 1'b1;
            end else begin
                osh_done_r <= osh_done_r;
            end
            if (i_read_status_reg[DW-1]) begin
                resp_cnt_r <= 16'd0;
            end else if (state_r == S_RESPONSE) begin
                resp_cnt_r <= resp_cnt_r + 16'd1;
            end else begin
                resp_cnt_r <= resp_cnt_r;
            end
        end
    end

    // Snoop channel outputs, registered from the next-cycle decode to line up with state_r.
    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn) begin
            crvalid_r <= 1'b0;
            crresp_r  <= 5'd0;
            cdvalid_r <= 1'b0;
            cdlast_r  <= 1'b0;
            rdata_r   <= {C_ACE_DATA_WIDTH{1'b0}};
        end else begin
            crvalid_r <= (next_state_s == S_RESPONSE);
            crresp_r  <= (next_state_s == S_RESPONSE) ? i_control_reg[13:9] : 5'd0;
            cdvalid_r <= beat_s;
            cdlast_r  <= last_s;
            rdata_r   <= beat_s ? {REP{i_acsnoop_reg[31:0]}} : {C_ACE_DATA_WIDTH{1'b0}};
        end
    end

    assign o_fsm_devil_state  = state_r;
    assign o_write_status_reg = {resp_cnt_r, 8'h00, state_r, 2'b00, osh_done_r, (state_r != S_IDLE)};
    assign snp.o_crvalid      = crvalid_r;
    assign snp.o_crresp       = crresp_r;
    assign snp.o_cdvalid      = cdvalid_r;
    assign snp.o_cdlast       = cdlast_r;
    assign snp.o_rdata        = rdata_r;
endmodule

// File: tb/tb_devil_in_fpga_core.sv
// Bench for devil_in_fpga_core: randomized configurations checked cycle by cycle
// against expected response traces built from the mode/test/delay rules.
module tb_devil_in_fpga_core;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  snoop, dstate;
    logic [31:0] ctrl, rsr, wsr, dly, acs, base, asz;
    int          total = 0;
    int          bad   = 0;
    int          m_cnt;
    logic        m_oshd;

    typedef struct packed {
        logic [3:0]   st;
        logic         crv;
        logic [4:0]   resp;
        logic         cdv;
        logic         cdl;
        logic [127:0] rd;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    devil_in_fpga_core_if #(.C_ACE_DATA_WIDTH(128)) snp ();

    devil_in_fpga_core #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_ACE_DATA_WIDTH(128),
        .DEVIL_EN(4'd10)
    ) dut (
        .ace_aclk(clk),
        .ace_aresetn(rstn),
        .i_snoop_state(snoop),
        .o_fsm_devil_state(dstate),
        .i_control_reg(ctrl),
        .i_read_status_reg(rsr),
        .o_write_status_reg(wsr),
        .i_delay_reg(dly),
        .i_acsnoop_reg(acs),
        .i_base_addr_reg(base),
        .i_addr_size_reg(asz),
        .snp(snp)
    );

    function automatic logic [31:0] mk_ctrl(input logic [3:0] tst, input logic [4:0] rs,
                                            input logic osh, input logic con, input logic en);
        logic [3:0] fn;
        fn = 4'($urandom);
        return {14'd0, con, osh, 2'b00, rs, fn, tst, en};
    endfunction

    function automatic exp_t mk(input logic [3:0] st, input logic crv, input logic [4:0] rs,
                                input logic cdv, input logic cdl, input logic [127:0] rd);
        return {st, crv, rs, cdv, cdl, rd};
    endfunction

    // One complete response: delay phase, response cycle, optional data phase.
    task automatic push_seq(input logic [3:0] dst, input int tst, input int d,
                            input logic [4:0] rs, input logic [31:0] pat);
        int eff, dm;
        logic [127:0] rd;
        eff = (tst >= 4) ? 1 : tst;
        dm  = (d == 0) ? 1 : d;
        rd  = {4{pat}};
        repeat ((eff == 0) ? 1 : dm) exp_q.push_back(mk(dst, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0));
        exp_q.push_back(mk(4'd3, 1'b1, rs, 1'b0, 1'b0, 128'd0));
        if (eff == 2) begin
            repeat (dm) exp_q.push_back(mk(4'd4, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0));
            for (int b = 0; b < 4; b++) exp_q.push_back(mk(4'd4, 1'b0, 5'd0, 1'b1, (b == 3), rd));
        end else if (eff == 3) begin
            for (int b = 0; b < 3; b++) exp_q.push_back(mk(4'd4, 1'b0, 5'd0, 1'b1, 1'b0, rd));
            repeat (dm) exp_q.push_back(mk(4'd4, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0));
            exp_q.push_back(mk(4'd4, 1'b0, 5'd0, 1'b1, 1'b1, rd));
        end
    endtask

    task automatic clear_count();
        rsr = 32'h8000_0000;
        @(posedge clk); @(negedge clk);
        rsr    = 32'd0;
        m_cnt  = 0;
        m_oshd = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++;
        if ({dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata, wsr} !==
            {4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset: state=%0d crv=%b cdv=%b cdl=%b status=%h, need all zero",
                     dstate, snp.o_crvalid, snp.o_cdvalid, snp.o_cdlast, wsr);
        end
        rstn = 1'b1;
    endtask

    task automatic test_continuous(input int tst, input int d, input logic [4:0] rs,
                                   input logic [31:0] pat, input int periods);
        int clr_at, nresp;
        exp_t e;
        clear_count();
        exp_q.delete();
        for (int p = 0; p < periods; p++) push_seq(4'd2, tst, d, rs, pat);
        nresp  = 0;
        clr_at = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].crv) begin
                nresp++;
                if (nresp == 2) clr_at = i;
            end
        end
        dly = d; acs = pat; snoop = 4'd0;
        ctrl = mk_ctrl(4'(tst), rs, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q[i];
            total++;
            if ({dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata, wsr} !==
                {e, m_cnt[15:0], 8'h00, e.st, 2'b00, m_oshd, (e.st != 4'd0)}) begin
                bad++;
                $display("FAIL cont t=%0d d=%0d cyc=%0d: got st=%0d crv=%b rsp=%h cdv=%b cdl=%b rd=%h stat=%h; need st=%0d crv=%b rsp=%h cdv=%b cdl=%b rd=%h cnt=%0d",
                         tst, d, i, dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast,
                         snp.o_rdata, wsr, e.st, e.crv, e.resp, e.cdv, e.cdl, e.rd, m_cnt);
            end
            rsr = (i == clr_at) ? 32'h8000_0000 : 32'd0;
            if (rsr[31]) m_cnt = 0;
            else if (e.crv) m_cnt++;
        end
        rsr  = 32'd0;
        ctrl = 32'd0;
        @(posedge clk); @(negedge clk);
        total++;
        if ({dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata, wsr[15:0]} !==
            {4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0, 16'd0}) begin
            bad++;
            $display("FAIL cont_stop: state=%0d crv=%b cdv=%b status=%h, need idle and quiet",
                     dstate, snp.o_crvalid, snp.o_cdvalid, wsr);
        end
    endtask

    task automatic test_one_shot(input int tst, input int d, input logic [4:0] rs, input logic [31:0] pat);
        exp_t e;
        clear_count();
        exp_q.delete();
        push_seq(4'd1, tst, d, rs, pat);
        exp_q.push_back(mk(4'd5, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0));
        repeat (5) exp_q.push_back(mk(4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0));
        dly = d; acs = pat; snoop = 4'd10;
        ctrl = mk_ctrl(4'(tst), rs, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q[i];
            total++;
            if ({dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata, wsr} !==
                {e, m_cnt[15:0], 8'h00, e.st, 2'b00, m_oshd, (e.st != 4'd0)}) begin
                bad++;
                $display("FAIL oneshot t=%0d d=%0d cyc=%0d: got st=%0d crv=%b rsp=%h cdv=%b cdl=%b stat=%h; need st=%0d crv=%b rsp=%h cdv=%b cdl=%b cnt=%0d done=%b",
                         tst, d, i, dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast,
                         wsr, e.st, e.crv, e.resp, e.cdv, e.cdl, m_cnt, m_oshd);
            end
            if (e.crv) m_cnt++;
            if (e.st == 4'd5) m_oshd = 1'b1;
        end
        ctrl = mk_ctrl(4'(tst), rs, 1'b0, 1'b0, 1'b1);
        @(posedge clk); @(negedge clk);
        total++;
        if ({dstate, wsr} !== {4'd0, m_cnt[15:0], 16'h0000}) begin
            bad++;
            $display("FAIL oneshot_release: state=%0d status=%h, need state 0 status %h",
                     dstate, wsr, {m_cnt[15:0], 16'h0000});
        end
        ctrl = 32'd0; snoop = 4'd0;
    endtask

    task automatic test_con_clear(input int tst, input int d);
        int cut, dm;
        logic [4:0]  rs;
        logic [31:0] pat;
        exp_t e;
        rs  = 5'($urandom);
        pat = $urandom;
        dm  = (d == 0) ? 1 : d;
        cut = $urandom_range(0, dm - 1);
        clear_count();
        exp_q.delete();
        push_seq(4'd2, tst, d, rs, pat);
        repeat (3) exp_q.push_back(mk(4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0));
        dly = d; acs = pat; snoop = 4'd0;
        ctrl = mk_ctrl(4'(tst), rs, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q[i];
            total++;
            if ({dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata, wsr} !==
                {e, m_cnt[15:0], 8'h00, e.st, 2'b00, 1'b0, (e.st != 4'd0)}) begin
                bad++;
                $display("FAIL con_clear t=%0d d=%0d cyc=%0d: got st=%0d crv=%b cdv=%b cdl=%b stat=%h; need st=%0d crv=%b cdv=%b cdl=%b cnt=%0d",
                         tst, d, i, dstate, snp.o_crvalid, snp.o_cdvalid, snp.o_cdlast, wsr,
                         e.st, e.crv, e.cdv, e.cdl, m_cnt);
            end
            if (e.crv) m_cnt++;
            if (i == cut) ctrl[17] = 1'b0;
        end
        ctrl = 32'd0;
    endtask

    task automatic test_abort(input int tst, input int d);
        int cut, first_d, last_d;
        logic [31:0] pat;
        exp_t e;
        pat = $urandom;
        clear_count();
        exp_q.delete();
        push_seq(4'd2, tst, d, 5'h01, pat);
        first_d = -1;
        last_d  = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].st == 4'd4) begin
                if (first_d < 0) first_d = i;
                last_d = i;
            end
        end
        cut = $urandom_range(first_d, last_d - 1);
        dly = d; acs = pat; snoop = 4'd0;
        ctrl = mk_ctrl(4'(tst), 5'h01, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i <= cut; i++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q[i];
            total++;
            if ({dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata} !== e) begin
                bad++;
                $display("FAIL abort_pre t=%0d d=%0d cyc=%0d: got st=%0d crv=%b cdv=%b cdl=%b rd=%h; need st=%0d crv=%b cdv=%b cdl=%b rd=%h",
                         tst, d, i, dstate, snp.o_crvalid, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata,
                         e.st, e.crv, e.cdv, e.cdl, e.rd);
            end
        end
        ctrl[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if ({dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata, wsr[15:0]} !==
            {4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0, 16'd0}) begin
            bad++;
            $display("FAIL abort t=%0d d=%0d cut=%0d: state=%0d crv=%b cdv=%b cdl=%b status=%h, need idle and quiet",
                     tst, d, cut, dstate, snp.o_crvalid, snp.o_cdvalid, snp.o_cdlast, wsr);
        end
        ctrl = 32'd0;
    endtask

    task automatic test_reset_mid();
        dly = 32'd3; acs = $urandom; snoop = 4'd0;
        ctrl = mk_ctrl(4'd2, 5'h1f, 1'b0, 1'b1, 1'b1);
        repeat ($urandom_range(4, 9)) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if ({dstate, snp.o_crvalid, snp.o_crresp, snp.o_cdvalid, snp.o_cdlast, snp.o_rdata, wsr} !==
            {4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 128'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_mid: state=%0d crv=%b cdv=%b status=%h, need all zero",
                     dstate, snp.o_crvalid, snp.o_cdvalid, wsr);
        end
        rstn = 1'b1;
        ctrl = 32'd0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within 2 ms");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; snoop = 4'd0; ctrl = 32'd0; rsr = 32'd0; dly = 32'd0;
        acs = 32'd0; base = $urandom; asz = $urandom;
        m_cnt = 0; m_oshd = 1'b0;
        test_reset();
        @(negedge clk);
        test_one_shot(1, 1, 5'h00, 32'h1234_5678);
        test_continuous(1, 1, 5'h00, 32'h0, 5);
        test_continuous(1, 5, 5'h0a, 32'h0, 3);
        test_continuous(2, 3, 5'h01, 32'hA5A5_A5A5, 2);
        test_continuous(3, 2, 5'h01, 32'h5A5A_0FF0, 2);
        test_continuous(0, 4, 5'h13, 32'h0, 4);
        test_continuous(2, 0, 5'h02, 32'hDEAD_BEEF, 2);
        test_abort(3, 2);
        test_abort(2, 3);
        for (int it = 0; it < 8; it++) begin
            test_continuous($urandom_range(0, 7), $urandom_range(0, 6), 5'($urandom), $urandom, 3);
            test_one_shot($urandom_range(0, 7), $urandom_range(0, 5), 5'($urandom), $urandom);
            test_con_clear($urandom_range(1, 3), $urandom_range(1, 5));
            test_abort($urandom_range(2, 3), $urandom_range(1, 6));
        end
        test_reset_mid();
        test_one_shot(3, 2, 5'h07, 32'hCAFE_F00D);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
